// File: rtl/ref_mer_meter.sv
// Per-window I/Q reference-level and squared-slicer-error meter with valid/ack readout.
// Optional IIR smoothing of the reference levels is enabled by defining REF_SMOOTH_EN.
module ref_mer_meter #(
    parameter int WIDTH        = 18,
    parameter int LOG2_WIN     = 16,
    parameter int REF_INIT     = 1460,
    parameter int SMOOTH_SHIFT = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sym_clk_ena,
    input  logic signed [WIDTH-1:0]        recovered_i,
    input  logic signed [WIDTH-1:0]        recovered_q,
    input  logic signed [WIDTH-1:0]        filt_i,
    input  logic signed [WIDTH-1:0]        filt_q,
    input  logic [1:0]                     slice_i,
    input  logic [1:0]                     slice_q,
    input  logic                           meas_ack,
    output logic [WIDTH-1:0]               ref_i,
    output logic [WIDTH-1:0]               ref_q,
    output logic [2*WIDTH:0]               ref_power_i,
    output logic [2*WIDTH:0]               ref_power_q,
    output logic [2*WIDTH+LOG2_WIN-1:0]    err_sq_i,
    output logic [2*WIDTH+LOG2_WIN-1:0]    err_sq_q,
    output logic                           meas_valid,
    output logic                           overrun,
    output logic [LOG2_WIN-1:0]            win_count
);
    localparam int ACC_W = WIDTH - 1 + LOG2_WIN;
    localparam int SQ_W  = 2 * WIDTH;
    localparam int ESQ_W = 2 * WIDTH + LOG2_WIN;
    localparam int PW_W  = 2 * WIDTH + 1;
    localparam logic [WIDTH-1:0] REF_RST = WIDTH'(REF_INIT);
    localparam logic [PW_W-1:0]  PW_RST  = PW_W'((64'(5) * 64'(REF_INIT) * 64'(REF_INIT)) >> 2);

    function automatic logic [WIDTH-2:0] abs_sat(input logic signed [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] n;
        n = -x;
        if (x == {1'b1, {(WIDTH-1){1'b0}}}) return '1;
        if (x[WIDTH-1]) return n[WIDTH-2:0];
        return x[WIDTH-2:0];
    endfunction

    function automatic logic signed [WIDTH:0] remap(input logic [WIDTH-1:0] r, input logic [1:0] code);
        logic signed [WIDTH:0] a, o;
        a = $signed({2'b00, r[WIDTH-1:1]});
        o = $signed({1'b0, r}) + a;
        case (code)
            2'b00:   return -o;
            2'b01:   return -a;
            2'b10:   return a;
            default: return o;
        endcase
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_err(input logic signed [WIDTH+1:0] d);
        if (d[WIDTH+1:WIDTH-1] == 3'b000 || d[WIDTH+1:WIDTH-1] == 3'b111) return d[WIDTH-1:0];
        return d[WIDTH+1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    function automatic logic [PW_W-1:0] power(input logic [WIDTH-1:0] r);
        logic [PW_W+1:0] sq;
        sq = (PW_W+2)'(r) * (PW_W+2)'(r);
        sq = sq + (sq << 2);
        return sq[PW_W+1:2];
    endfunction

`ifdef REF_SMOOTH_EN
    function automatic logic [WIDTH-1:0] smooth(input logic [WIDTH-1:0] cur, input logic [WIDTH-1:0] nm);
        logic signed [WIDTH+1:0] d, s;
        d = $signed({2'b00, nm}) - $signed({2'b00, cur});
        s = $signed({2'b00, cur}) + (d >>> SMOOTH_SHIFT);
        if (s[WIDTH+1]) return '0;
        if (s[WIDTH:WIDTH-1] != 2'b00) return {1'b0, {(WIDTH-1){1'b1}}};
        return s[WIDTH-1:0];
    endfunction
`endif

    logic [ACC_W-1:0]        acc_i, acc_q, sum_i_p0, sum_q_p0;
    logic [ESQ_W-1:0]        esq_acc_i, esq_acc_q, esum_i_p0, esum_q_p0;
    logic signed [WIDTH+1:0] diff_i_p0, diff_q_p0;
    logic signed [SQ_W-1:0]  e_i_p0, e_q_p0;
    logic [SQ_W-1:0]         sq_i_p0, sq_q_p0;
    logic [WIDTH-1:0]        mean_i_p0, mean_q_p0, next_ref_i, next_ref_q;
    logic                    close_p0;

    // Stage p0: per-symbol abs, remap error and window totals including the current symbol
    always_comb begin
        close_p0   = sym_clk_ena && (win_count == '1);
        sum_i_p0   = acc_i + ACC_W'(abs_sat(recovered_i));
        sum_q_p0   = acc_q + ACC_W'(abs_sat(recovered_q));
        diff_i_p0  = filt_i - remap(ref_i, slice_i);
        diff_q_p0  = filt_q - remap(ref_q, slice_q);
        e_i_p0     = SQ_W'(sat_err(diff_i_p0));
        e_q_p0     = SQ_W'(sat_err(diff_q_p0));
        sq_i_p0    = e_i_p0 * e_i_p0;
        sq_q_p0    = e_q_p0 * e_q_p0;
        esum_i_p0  = esq_acc_i + ESQ_W'(sq_i_p0);
        esum_q_p0  = esq_acc_q + ESQ_W'(sq_q_p0);
        mean_i_p0  = {1'b0, sum_i_p0[ACC_W-1:LOG2_WIN]};
        mean_q_p0  = {1'b0, sum_q_p0[ACC_W-1:LOG2_WIN]};
`ifdef REF_SMOOTH_EN
        next_ref_i = smooth(ref_i, mean_i_p0);
        next_ref_q = smooth(ref_q, mean_q_p0);
`else
        next_ref_i = mean_i_p0;
        next_ref_q = mean_q_p0;
`endif
    end

    // Stage p1: accumulators, window results and handshake; ref_power trails ref by one register
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_i       <= '0;
            acc_q       <= '0;
            esq_acc_i   <= '0;
            esq_acc_q   <= '0;
            ref_i       <= REF_RST;
            ref_q       <= REF_RST;
            ref_power_i <= PW_RST;
            ref_power_q <= PW_RST;
            err_sq_i    <= '0;
            err_sq_q    <= '0;
            meas_valid  <= 1'b0;
            overrun     <= 1'b0;
            win_count   <= '0;
        end else begin
            ref_power_i <= power(ref_i);
            ref_power_q <= power(ref_q);
            if (sym_clk_ena) begin
                win_count <= win_count + LOG2_WIN'(1);
                if (close_p0) begin
                    acc_i     <= '0;
                    acc_q     <= '0;
                    esq_acc_i <= '0;
                    esq_acc_q <= '0;
                    ref_i     <= next_ref_i;
                    ref_q     <= next_ref_q;
                    err_sq_i  <= esum_i_p0;
                    err_sq_q  <= esum_q_p0;
                end else begin
                    acc_i     <= sum_i_p0;
                    acc_q     <= sum_q_p0;
                    esq_acc_i <= esum_i_p0;
                    esq_acc_q <= esum_q_p0;
                end
            end
            // A close always leaves results pending; an ack on the same cycle only clears overrun
            if (close_p0) begin
                meas_valid <= 1'b1;
                if (meas_valid && !meas_ack) overrun <= 1'b1;
                else if (meas_valid && meas_ack) overrun <= 1'b0;
            end else if (meas_valid && meas_ack) begin
                meas_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end
endmodule
